// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-organised data RAM: checks alignment and range,
// does read-modify-write for sub-word stores and extends sub-word load data.
module mem_access_unit #(
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

   localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

   state_t      state_reg;
   logic [1:0]  lane_reg;
   logic [1:0]  size_reg;
   logic        signed_reg;
   logic        we_reg;
   logic [31:0] wdata_reg;
   logic [31:0] word_buf_reg;

   logic        misaligned;
   logic        out_of_range;
   logic        req_err;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   assign req_ready = (state_reg == IDLE);

   always_comb begin
      misaligned   = (req_size == 2'b11)
                   | ((req_size == 2'b01) & req_addr[0])
                   | ((req_size == 2'b10) & (|req_addr[1:0]));
      out_of_range = (req_addr[ADDR_W-1:2] >= WORD_LIMIT);
      req_err      = misaligned | out_of_range;
   end

   // Sub-word load extraction works straight off the RAM read data at the end of RD.
   always_comb begin
      byte_sel  = mem_rdata[{lane_reg, 3'b000} +: 8];
      half_sel  = mem_rdata[{lane_reg[1], 4'b0000} +: 16];
      load_data = mem_rdata;
      case (size_reg)
         2'b00:   load_data = {{24{signed_reg & byte_sel[7]}}, byte_sel};
         2'b01:   load_data = {{16{signed_reg & half_sel[15]}}, half_sel};
         default: load_data = mem_rdata;
      endcase
   end

   // Word stores bypass word_buf entirely; sub-word stores patch one lane of it.
   always_comb begin
      merged_word = word_buf_reg;
      case (size_reg)
         2'b00:   merged_word[{lane_reg, 3'b000} +: 8]     = wdata_reg[7:0];
         2'b01:   merged_word[{lane_reg[1], 4'b0000} +: 16] = wdata_reg[15:0];
         default: merged_word = wdata_reg;
      endcase
   end

   assign mem_wdata = merged_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         lane_reg     <= '0;
         size_reg     <= '0;
         signed_reg   <= 1'b0;
         we_reg       <= 1'b0;
         wdata_reg    <= '0;
         word_buf_reg <= '0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  lane_reg   <= req_addr[1:0];
                  size_reg   <= req_size;
                  signed_reg <= req_signed;
                  we_reg     <= req_we;
                  wdata_reg  <= req_wdata;
                  if (req_err) begin
                     state_reg  <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     if (req_we && req_size == 2'b10) begin
                        state_reg <= WR;
                        mem_we    <= 1'b1;
                     end else begin
                        state_reg <= RD;
                     end
                  end
               end
            end
            RD: begin
               word_buf_reg <= mem_rdata;
               if (we_reg) begin
                  state_reg <= WR;
                  mem_we    <= 1'b1;
               end else begin
                  state_reg  <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= load_data;
               end
            end
            WR: begin
               mem_we     <= 1'b0;
               state_reg  <= RESP;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
            end
            RESP: begin
               if (resp_ready) begin
                  state_reg  <= IDLE;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 64 x 32-bit behavioural RAM attached.
module tb_mem_access_unit;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] ram [64];
   int          we_count;
   logic [31:0] last_waddr;
   logic [31:0] last_wdata;

   int n_pass;
   int n_total;

   mem_access_unit #(.ADDR_W(32), .MEM_WORDS(64)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = ram[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr[7:2]] <= mem_wdata;
         we_count   <= we_count + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // One full transaction: accept, wait for response (bounded), then consume it.
   task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdata,
                        output logic err, output int wes);
      int we0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
      we0        = we_count;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      rdata = resp_rdata;
      err   = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      wes = we_count - we0;
      $display("txn we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h writes=%0d",
               we, size, sgn, addr, wd, lat, err, rdata, wes);
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic        er;
      int          wes;
      logic [31:0] held;
      int          we_snap;

      n_pass = 0; n_total = 0; we_count = 0;
      last_waddr = '0; last_wdata = '0;
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_flags", {28'h0, req_ready, resp_valid, resp_err, mem_we}, 32'h8);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      rst_n = 1'b1;

      // Word store then word load
      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, wes);
      chk("wst_lat", lat, 2);
      chk("wst_err", {31'h0, er}, 32'h0);
      chk("wst_pulses", wes, 1);
      chk("wst_addr", last_waddr, 32'h10);
      chk("wst_data", last_wdata, 32'hDEADBEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, wes);
      chk("wld_lat", lat, 2);
      chk("wld_data", rd, 32'hDEADBEEF);
      chk("wld_pulses", wes, 0);

      // Byte read-modify-write
      issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, lat, rd, er, wes);
      issue(1'b1, 2'b00, 1'b0, 32'h22, 32'h123456AA, lat, rd, er, wes);
      chk("bst_lat", lat, 3);
      chk("bst_err", {31'h0, er}, 32'h0);
      chk("bst_pulses", wes, 1);
      chk("bst_addr", last_waddr, 32'h20);
      chk("bst_data", last_wdata, 32'h11AA3344);
      chk("bst_ram", ram[8], 32'h11AA3344);

      // Half store into upper lane of 0xDEADBEEF
      issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFFCAFE, lat, rd, er, wes);
      chk("hst_lat", lat, 3);
      chk("hst_data", last_wdata, 32'hCAFEBEEF);

      // Signed / unsigned sub-word loads
      issue(1'b1, 2'b10, 1'b0, 32'h04, 32'h80F07F01, lat, rd, er, wes);
      issue(1'b0, 2'b00, 1'b1, 32'h06, 32'h0, lat, rd, er, wes);
      chk("ldrsb_06", rd, 32'hFFFFFFF0);
      chk("ldrsb_lat", lat, 2);
      issue(1'b0, 2'b00, 1'b0, 32'h06, 32'h0, lat, rd, er, wes);
      chk("ldrb_06", rd, 32'h000000F0);
      issue(1'b0, 2'b01, 1'b1, 32'h04, 32'h0, lat, rd, er, wes);
      chk("ldrsh_04", rd, 32'h00007F01);
      issue(1'b0, 2'b01, 1'b1, 32'h06, 32'h0, lat, rd, er, wes);
      chk("ldrsh_06", rd, 32'hFFFF80F0);
      issue(1'b0, 2'b01, 1'b0, 32'h06, 32'h0, lat, rd, er, wes);
      chk("ldrh_06", rd, 32'h000080F0);
      issue(1'b0, 2'b00, 1'b1, 32'h07, 32'h0, lat, rd, er, wes);
      chk("ldrsb_07", rd, 32'hFFFFFF80);
      issue(1'b0, 2'b00, 1'b1, 32'h05, 32'h0, lat, rd, er, wes);
      chk("ldrsb_05", rd, 32'h0000007F);

      // Error paths
      issue(1'b0, 2'b01, 1'b0, 32'h05, 32'h0, lat, rd, er, wes);
      chk("mis_err", {31'h0, er}, 32'h1);
      chk("mis_rdata", rd, 32'h0);
      chk("mis_lat", lat, 1);
      chk("mis_pulses", wes, 0);
      issue(1'b1, 2'b10, 1'b0, 32'h100, 32'h55555555, lat, rd, er, wes);
      chk("oor_err", {31'h0, er}, 32'h1);
      chk("oor_lat", lat, 1);
      chk("oor_pulses", wes, 0);
      issue(1'b1, 2'b10, 1'b0, 32'h02, 32'h66666666, lat, rd, er, wes);
      chk("wmis_err", {31'h0, er}, 32'h1);
      chk("wmis_pulses", wes, 0);
      issue(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, lat, rd, er, wes);
      chk("sz11_err", {31'h0, er}, 32'h1);
      issue(1'b1, 2'b10, 1'b0, 32'hFC, 32'h0BADF00D, lat, rd, er, wes);
      chk("last_err", {31'h0, er}, 32'h0);
      chk("last_ram", ram[63], 32'h0BADF00D);
      chk("ram1_kept", ram[1], 32'h80F07F01);

      // Backpressure on a load
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 32'h10;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 20);
      chk("bp_lat", lat, 2);
      held = resp_rdata;
      chk("bp_data", held, 32'hCAFEBEEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {29'h0, resp_valid, req_ready, resp_err}, 32'h4);
         chk("bp_stable", resp_rdata, 32'hCAFEBEEF);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("bp_release", {30'h0, req_ready, resp_valid}, 32'h2);
      $display("txn backpressure load addr=00000010 -> rdata=%h", held);

      // Reset during the read phase of a byte store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h00000055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      we_snap = we_count;
      chk("mid_rd_addr", mem_addr, 32'h20);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_flags", {28'h0, req_ready, resp_valid, resp_err, mem_we}, 32'h8);
      chk("mid_rst_addr", mem_addr, 32'h0);
      chk("mid_rst_wdata", mem_wdata, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_pulses", we_count - we_snap, 0);
      chk("mid_rst_ram", ram[8], 32'h11AA3344);
      chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
      $display("txn reset during byte store addr=00000021 -> ram[8]=%h", ram[8]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front-end sitting directly upstream of the word-organised data RAM (64 x 32-bit, asynchronous read, synchronous write).
- Accepts byte, halfword and word load/store requests from the datapath, and performs read-modify-write for sub-word stores so the RAM only sees full-word writes.
- Extracts and zero- or sign-extends sub-word load data.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 32, byte-address width.
- MEM_WORDS, 64, RAM depth in 32-bit words; word index >= MEM_WORDS is out of range.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request; equals (state==IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as misaligned.
- req_signed  input  1  sign-extend a sub-word load; ignored for stores and word loads.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- resp_valid  output  1  response available.
- resp_ready  input  1  datapath accepts the response.
- resp_rdata  output  32  load result, extended; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range access.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ADDR_W  RAM address, always word-aligned ({word index, 2'b00}).
- mem_wdata  output  32  full word written to the RAM.
- mem_rdata  input  32  RAM asynchronous read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All latched request fields are cleared.
  - Reset mid-operation abandons the operation. mem_we drops immediately and no partial write completes.
- Handshake:
  - A request is accepted on a rising edge with req_valid && req_ready. Address, size, signed, we and wdata are latched at that edge.
  - Request inputs are don't-care outside acceptance.
  - Only one request is in flight at a time.
- Error check at acceptance:
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - Out of range: addr[ADDR_W-1:2] >= MEM_WORDS.
  - Error path: IDLE -> RESP with resp_err=1 and resp_rdata=0. No RAM access; mem_we is never asserted.
- States:
  - IDLE. Word store -> WR. Sub-word store -> RD. Load -> RD. Error -> RESP.
  - RD, 1 cycle. mem_addr drives the latched word address. mem_rdata is captured into word_buf at the end of the cycle. Next state: WR for a store, RESP for a load.
  - WR, 1 cycle. mem_we=1 and mem_wdata=merged word. Next state: RESP.
  - RESP. resp_valid=1; outputs stay stable until resp_ready=1. That edge returns to IDLE.
- Merge rule for stores:
  - Byte: lane addr[1:0] of word_buf is replaced with wdata[7:0].
  - Half: lane addr[1] (bits 15:0 or 31:16) is replaced with wdata[15:0].
  - Word: wdata is written as-is; no read is performed.
- Load extraction:
  - Byte lane addr[1:0], half lane addr[1].
  - Zero-extend, or sign-extend from the lane MSB when req_signed=1.
  - resp_rdata is registered on the RD->RESP transition.
- Latency from acceptance edge to resp_valid:
  - Load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Outside WR, mem_we=0. mem_addr holds its last value when the unit is not accessing memory.
- resp_valid && resp_ready returns to IDLE, with req_ready=1 the following cycle. There is no same-cycle accept while in RESP.
- req_valid while the unit is busy is ignored; the requester must hold it.

Test Plan:
- Word store then load: store 0xDEADBEEF at 0x10 -> mem_we pulses 1 cycle with mem_addr=0x10 and mem_wdata=0xDEADBEEF. Word load at 0x10 -> resp_rdata=0xDEADBEEF 2 cycles after accept.
- Byte RMW: word 0x11223344 at 0x20, store byte 0xAA at 0x22 -> RD then WR; mem_wdata=0x11AA3344; resp_err=0.
- Signed/unsigned loads: word 0x80F07F01 at 0x04:
  - LDRSB 0x06 -> 0xFFFFFFF0.
  - LDRB 0x06 -> 0x000000F0.
  - LDRSH 0x04 -> 0x00007F01.
  - LDRSH 0x06 -> 0xFFFF80F0.
- Errors:
  - Half load at 0x05 -> resp_err=1, resp_rdata=0, 1-cycle latency, mem_we never asserted.
  - Word store at byte address 4*MEM_WORDS (0x100) -> resp_err=1.
- Backpressure: resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stay stable and req_ready=0. resp_ready=1 -> req_ready=1 the next cycle.
- Reset mid-RMW: assert rst_n=0 during the RD state of a byte store -> all outputs return to reset values immediately. RAM contents are unchanged and no write pulse occurs.
